// File: rtl/gen_relojes_multi.sv
// rtl/gen_relojes_multi.sv - multi-rate aligned clock generator with programmable divisor
// One prescaler plus one phase counter drive all outputs, so every clk_out edge is aligned.
module gen_relojes_multi #(
   parameter int NUM_CH      = 3,
   parameter int CNT_W       = 16,
   parameter int DEFAULT_DIV = 6
) (
   input  logic              clk_in,
   input  logic              reset_L,
   input  logic              en,
   input  logic [CNT_W-1:0]  div_in,
   input  logic              div_load,
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] rise_stb,
   output logic              running,
   output logic              div_busy,
   output logic              div_err
);

   typedef enum logic {STOPPED = 1'b0, RUN = 1'b1} state_t;

   state_t            state, state_nx;
   logic [CNT_W-1:0]  pre, pre_nx;
   logic [CNT_W-1:0]  active_div, active_nx;
   logic [CNT_W-1:0]  pending, pending_nx;
   logic [CNT_W-1:0]  half;
   logic [NUM_CH-1:0] phase, phase_nx;
   logic [NUM_CH-1:0] stb_nx;
   logic              busy_nx, err_nx;
   logic              wrap, boundary, load_ok;

   assign half     = active_div >> 1;
   assign wrap     = (state == RUN) && (pre == half - CNT_W'(1));
   assign boundary = wrap && (&phase);
   assign load_ok  = !div_in[0] && (div_in >= CNT_W'(2));

   assign clk_out  = phase;
   assign running  = (state == RUN);

   always_comb begin
      state_nx   = state;
      pre_nx     = pre;
      phase_nx   = phase;
      active_nx  = active_div;
      pending_nx = pending;
      busy_nx    = div_busy;
      err_nx     = 1'b0;
      case (state)
         STOPPED: begin
            pre_nx   = '0;
            phase_nx = '0;
            if (div_busy) begin
               active_nx = pending;
               busy_nx   = 1'b0;
            end
            if (en) state_nx = RUN;
         end
         RUN: begin
            if (wrap) begin
               pre_nx   = '0;
               phase_nx = phase + NUM_CH'(1);
            end else begin
               pre_nx = pre + CNT_W'(1);
            end
            // Divisor swap and stop only at the all-low boundary so no phase is truncated.
            if (boundary) begin
               if (div_busy) begin
                  active_nx = pending;
                  busy_nx   = 1'b0;
               end
               if (!en) state_nx = STOPPED;
            end
         end
         default: state_nx = STOPPED;
      endcase
      // A load in the boundary cycle overrides the clear above and waits for the next boundary.
      if (div_load) begin
         if (load_ok) begin
            pending_nx = div_in;
            busy_nx    = 1'b1;
         end else begin
            err_nx = 1'b1;
         end
      end
      stb_nx = phase_nx & ~phase;
   end

   always_ff @(posedge clk_in or negedge reset_L) begin
      if (!reset_L) begin
         state      <= STOPPED;
         pre        <= '0;
         phase      <= '0;
         active_div <= CNT_W'(DEFAULT_DIV);
         pending    <= '0;
         div_busy   <= 1'b0;
         div_err    <= 1'b0;
         rise_stb   <= '0;
      end else begin
         state      <= state_nx;
         pre        <= pre_nx;
         phase      <= phase_nx;
         active_div <= active_nx;
         pending    <= pending_nx;
         div_busy   <= busy_nx;
         div_err    <= err_nx;
         rise_stb   <= stb_nx;
      end
   end

endmodule

// File: tb/tb_gen_relojes_multi.sv
// tb/tb_gen_relojes_multi.sv - self-checking bench for gen_relojes_multi
// Reference model tracks position within the full super-period rather than prescaler/phase.
module tb_gen_relojes_multi;

   localparam int NUM_CH = 3;
   localparam int CNT_W  = 16;

   logic              clk_in = 1'b0;
   logic              reset_L;
   logic              en;
   logic [CNT_W-1:0]  div_in;
   logic              div_load;
   logic [NUM_CH-1:0] clk_out;
   logic [NUM_CH-1:0] rise_stb;
   logic              running;
   logic              div_busy;
   logic              div_err;

   gen_relojes_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_DIV(6)) dut (
      .clk_in   (clk_in),
      .reset_L  (reset_L),
      .en       (en),
      .div_in   (div_in),
      .div_load (div_load),
      .clk_out  (clk_out),
      .rise_stb (rise_stb),
      .running  (running),
      .div_busy (div_busy),
      .div_err  (div_err)
   );

   always #5 clk_in = ~clk_in;

   int n_cmp = 0;
   int n_err = 0;

   // reference model state
   bit                m_run;
   int                m_pos;
   int                m_div;
   int                m_pend;
   bit                m_busy;
   bit                m_err;
   logic [NUM_CH-1:0] m_clk;
   logic [NUM_CH-1:0] m_stb;

   typedef struct {
      bit          e;
      bit          ld;
      logic [15:0] din;
      logic [2:0]  clk;
      logic [2:0]  stb;
      bit          run;
      bit          busy;
      bit          err;
   } vec_t;

   vec_t vecs[10];

   task automatic cmp(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_run = 0; m_pos = 0; m_div = 6; m_pend = 0; m_busy = 0; m_err = 0;
      m_clk = '0; m_stb = '0;
   endtask

   task automatic m_step(input bit e, input bit ld, input logic [15:0] d);
      logic [NUM_CH-1:0] nclk;
      int super_len;
      m_err = 0;
      if (m_run) begin
         super_len = (m_div / 2) << NUM_CH;
         if (m_pos == super_len - 1) begin
            m_pos = 0;
            if (m_busy) begin m_div = m_pend; m_busy = 0; end
            if (!e) m_run = 0;
         end else begin
            m_pos++;
         end
      end else begin
         m_pos = 0;
         if (m_busy) begin m_div = m_pend; m_busy = 0; end
         if (e) m_run = 1;
      end
      if (ld) begin
         if (d[0] == 1'b0 && d >= 16'd2) begin m_pend = int'(d); m_busy = 1; end
         else m_err = 1;
      end
      for (int k = 0; k < NUM_CH; k++)
         nclk[k] = m_run && (((m_pos / ((m_div / 2) << k)) % 2) == 1);
      m_stb = nclk & ~m_clk;
      m_clk = nclk;
   endtask

   task automatic step(input bit e, input bit ld, input logic [15:0] d);
      en = e; div_load = ld; div_in = d;
      m_step(e, ld, d);
      @(posedge clk_in);
      @(negedge clk_in);
      cmp("clk_out", int'(clk_out), int'(m_clk));
      cmp("rise_stb", int'(rise_stb), int'(m_stb));
      cmp("running", int'(running), int'(m_run));
      cmp("div_busy", int'(div_busy), int'(m_busy));
      cmp("div_err", int'(div_err), int'(m_err));
   endtask

   task automatic measure_period(input int k, input int exp, input string name);
      int c;
      c = 0;
      while (!rise_stb[k] && c < 400) begin step(1, 0, 0); c++; end
      c = 0;
      do begin step(1, 0, 0); c++; end while (!rise_stb[k] && c < 400);
      cmp(name, c, exp);
   endtask

   initial begin
      int c;
      int cnt[NUM_CH];
      logic [15:0] d;

      vecs[0] = '{1, 0, 16'd0, 3'b000, 3'b000, 1, 0, 0};
      vecs[1] = '{1, 0, 16'd0, 3'b000, 3'b000, 1, 0, 0};
      vecs[2] = '{1, 1, 16'd7, 3'b000, 3'b000, 1, 0, 1};
      vecs[3] = '{1, 0, 16'd0, 3'b001, 3'b001, 1, 0, 0};
      vecs[4] = '{1, 1, 16'd0, 3'b001, 3'b000, 1, 0, 1};
      vecs[5] = '{1, 1, 16'd1, 3'b001, 3'b000, 1, 0, 1};
      vecs[6] = '{1, 0, 16'd0, 3'b010, 3'b010, 1, 0, 0};
      vecs[7] = '{1, 0, 16'd0, 3'b010, 3'b000, 1, 0, 0};
      vecs[8] = '{1, 0, 16'd0, 3'b010, 3'b000, 1, 0, 0};
      vecs[9] = '{1, 0, 16'd0, 3'b011, 3'b001, 1, 0, 0};

      reset_L = 0; en = 1; div_in = '0; div_load = 0;
      m_reset();
      @(negedge clk_in);
      @(negedge clk_in);
      cmp("reset clk_out", int'(clk_out), 0);
      cmp("reset rise_stb", int'(rise_stb), 0);
      cmp("reset running", int'(running), 0);
      cmp("reset div_busy", int'(div_busy), 0);
      cmp("reset div_err", int'(div_err), 0);
      reset_L = 1;

      for (int i = 0; i < 10; i++) begin
         step(vecs[i].e, vecs[i].ld, vecs[i].din);
         cmp("vec clk_out", int'(clk_out), int'(vecs[i].clk));
         cmp("vec rise_stb", int'(rise_stb), int'(vecs[i].stb));
         cmp("vec running", int'(running), int'(vecs[i].run));
         cmp("vec div_busy", int'(div_busy), int'(vecs[i].busy));
         cmp("vec div_err", int'(div_err), int'(vecs[i].err));
      end

      for (int k = 0; k < NUM_CH; k++) cnt[k] = 0;
      for (int i = 0; i < 48; i++) begin
         step(1, 0, 0);
         for (int k = 0; k < NUM_CH; k++) if (rise_stb[k]) cnt[k]++;
      end
      cmp("rise count 0", cnt[0], 8);
      cmp("rise count 1", cnt[1], 4);
      cmp("rise count 2", cnt[2], 2);

      step(1, 0, 0);
      step(1, 1, 16'd10);
      cmp("load10 busy", int'(div_busy), 1);
      c = 0;
      while (div_busy && c < 200) begin step(1, 0, 0); c++; end
      cmp("load10 busy clears", int'(div_busy), 0);
      measure_period(0, 10, "period clk0 div10");
      measure_period(2, 40, "period clk2 div10");

      step(1, 0, 0);
      c = 0;
      while (running && c < 200) begin step(0, 0, 0); c++; end
      cmp("stop running", int'(running), 0);
      cmp("stop clk_out", int'(clk_out), 0);
      step(1, 0, 0);
      cmp("restart running", int'(running), 1);
      c = 0;
      while (!clk_out[0] && c < 100) begin step(1, 0, 0); c++; end
      cmp("restart first rise", c, 5);

      step(1, 0, 0);
      step(1, 1, 16'd8);
      step(1, 0, 0);
      #2 reset_L = 0;
      #1;
      cmp("async clk_out", int'(clk_out), 0);
      cmp("async running", int'(running), 0);
      cmp("async div_busy", int'(div_busy), 0);
      cmp("async rise_stb", int'(rise_stb), 0);
      m_reset();
      @(negedge clk_in);
      reset_L = 1;
      measure_period(0, 6, "period after reset");

      for (int i = 0; i < 1500; i++) begin
         case ($urandom_range(0, 3))
            0, 1:    d = 16'(2 * $urandom_range(1, 10));
            2:       d = 16'(2 * $urandom_range(0, 10) + 1);
            default: d = 16'($urandom_range(0, 1));
         endcase
         step($urandom_range(0, 99) < 90, $urandom_range(0, 19) == 0, d);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
